adc_spi_sampler: RTL
====================

Name: adc_spi_sampler

Overview:
Sample-source front end for the 12-bit signal-processing chain. It generates the sample-rate strobe f_s from clk and reads one conversion per sample period from a 12-bit SPI ADC. The ADC frame is 16 SCLK cycles: 4 leading zeros, then 12 data bits MSB-first, offset binary. It delivers a signed two's-complement sample on dout together with f_s. Filter cores capture dout on the rising edge of f_s, through their own two-flop edge detectors.

Parameters:
CLK_DIV, 2500, sample period in clk cycles (50 MHz / 2500 = 20 kHz); legal range 34*SCLK_DIV+FS_HIGH+2 .. 65535.
SCLK_DIV, 4, SCLK half-period in clk cycles; legal range 1..255.
FS_HIGH, 4, number of clk cycles f_s stays high per sample; must be >= 2.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
en  in  1  sampling enable
adc_miso  in  1  ADC serial data
adc_cs_n  out  1  ADC chip select, active-low
adc_sclk  out  1  ADC serial clock, idles low
dout  out  12 (signed)  latest sample, two's complement
f_s  out  1  sample strobe; rising edge marks a new dout
busy  out  1  conversion in progress

Behaviour:
- Reset values (rst=0, asynchronous):
  - adc_cs_n=1, adc_sclk=0, dout=0, f_s=0, busy=0.
  - Period counter = 0; FSM in IDLE; shift register = 0.
- Period counter:
  - Counts 0..CLK_DIV-1 and wraps while en=1 or while a conversion is active.
  - With en=0 and the FSM in IDLE, it is held at 0.
  - Start event = clk edge E0 at which the counter equals 0, en=1 and the FSM is IDLE.
- FSM: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE: cs_n=1, sclk=0. At E0: enter SETUP, cs_n<=0, busy<=1.
- SETUP: SCLK_DIV cycles, then enter SHIFT.
- SHIFT: 16 SCLK periods, each one SCLK_DIV cycles high then SCLK_DIV cycles low.
  - The first sclk rise occurs at E0+SCLK_DIV.
  - adc_miso is sampled on the clk edge that ends each high phase, i.e. the same edge that drives sclk low.
  - The sampled bit shifts into a 16-bit register, LSB-in.
  - A 5-bit bit counter tracks the 16 bits.
- HOLD: SCLK_DIV cycles after the last sclk fall. On the closing edge, E0+34*SCLK_DIV (=136 at default):
  - cs_n<=1, busy<=0;
  - dout <= {~sh[11], sh[10:0]} (offset-binary to two's complement);
  - f_s<=1;
  - FSM returns to IDLE.
- Leading bits: sh[15:12] (the 4 leading zeros) are discarded and not checked.
- f_s: stays high for exactly FS_HIGH cycles, then low until the next update.
  - One rising edge per sample period.
  - Successive rising edges are exactly CLK_DIV cycles apart while en=1.
- dout: changes only on the update edge and is stable for the full sample period.
  - Consumers sampling 2 cycles after the f_s rise see the new value.
- en deassert:
  - Mid-conversion: the conversion completes normally, including the dout/f_s update.
  - No further start events occur.
  - f_s finishes its FS_HIGH pulse.
- en reassert:
  - Counter at 0 and FSM IDLE: the start event occurs on the first edge with en=1.
  - Conversion still running: the next start occurs at counter wrap.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronous); the partial frame is discarded.
- Parameter violation (CLK_DIV too small, FS_HIGH<2): a simulation-only check reports a fatal error at time 0.

Test Plan:
1. Default parameters, en=1, ADC model returns code 0x800 -> dout=0; f_s rises at E0+136; cs_n low for 136 cycles; exactly 16 sclk rises.
2. Codes 0xFFF, 0x000, 0xA5C on consecutive samples -> dout=2047, -2048, +604; each f_s pulse is 4 cycles; rising edges 2500 cycles apart.
3. Leading nibble of the frame driven 0xF with data 0x123 -> dout=0x123-0x800=-1757; the leading bits are ignored.
4. en dropped 50 cycles after E0 -> the current sample still updates at E0+136; no further cs_n activity; en re-raised later -> cs_n falls on the first edge with en=1.
5. rst pulsed low during SHIFT (bit 7) -> cs_n=1, sclk=0, dout=0, f_s=0 immediately; after release with en=1, a clean frame starts at counter 0.
6. SCLK_DIV=1, CLK_DIV=40, FS_HIGH=2 -> update at E0+34; f_s period 40 cycles; alternating codes 0x7FF/0x801 give dout -1/+1.

Source files
------------

// File: rtl/adc_spi_sampler.sv
// Sample-rate strobe generator and 16-clock SPI reader for a 12-bit offset-binary ADC.
// Each frame delivers one two's-complement sample on dout, marked by a rising f_s.
module adc_spi_sampler #(
  parameter int CLK_DIV  = 2500,
  parameter int SCLK_DIV = 4,
  parameter int FS_HIGH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               adc_miso,
  output logic               adc_cs_n,
  output logic               adc_sclk,
  output logic signed [11:0] dout,
  output logic               f_s,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_e;

  localparam logic [15:0] CntMax = 16'(CLK_DIV - 1);
  localparam logic [7:0]  DivMax = 8'(SCLK_DIV - 1);
  localparam logic [15:0] FsMax  = 16'(FS_HIGH - 1);

  generate
    if (CLK_DIV < 34 * SCLK_DIV + FS_HIGH + 2 || CLK_DIV > 65535 ||
        SCLK_DIV < 1 || SCLK_DIV > 255 || FS_HIGH < 2) begin : gParamCheck
      $fatal(1, "adc_spi_sampler: illegal CLK_DIV/SCLK_DIV/FS_HIGH combination");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [15:0]        periodCnt_q, periodCnt_d;
  logic [7:0]         divCnt_q, divCnt_d;
  logic [4:0]         bitCnt_q, bitCnt_d;
  logic [15:0]        shift_q, shift_d;
  logic [15:0]        fsCnt_q, fsCnt_d;
  logic               csN_q, csN_d;
  logic               sclk_q, sclk_d;
  logic               fs_q, fs_d;
  logic               busy_q, busy_d;
  logic signed [11:0] dout_q, dout_d;
  logic               startEvt;
  logic               divTick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      periodCnt_q <= '0;
      divCnt_q    <= '0;
      bitCnt_q    <= '0;
      shift_q     <= '0;
      fsCnt_q     <= '0;
      csN_q       <= 1'b1;
      sclk_q      <= 1'b0;
      fs_q        <= 1'b0;
      busy_q      <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      periodCnt_q <= periodCnt_d;
      divCnt_q    <= divCnt_d;
      bitCnt_q    <= bitCnt_d;
      shift_q     <= shift_d;
      fsCnt_q     <= fsCnt_d;
      csN_q       <= csN_d;
      sclk_q      <= sclk_d;
      fs_q        <= fs_d;
      busy_q      <= busy_d;
      dout_q      <= dout_d;
    end
  end

  // One divider tick per SCLK half-period; every FSM step happens on a tick.
  always_comb begin
    state_d     = state_q;
    periodCnt_d = periodCnt_q;
    divCnt_d    = '0;
    bitCnt_d    = bitCnt_q;
    shift_d     = shift_q;
    fsCnt_d     = fsCnt_q;
    csN_d       = csN_q;
    sclk_d      = sclk_q;
    fs_d        = fs_q;
    busy_d      = busy_q;
    dout_d      = dout_q;

    startEvt = (state_q == IDLE) && en && (periodCnt_q == '0);
    divTick  = (divCnt_q == DivMax);

    if (en || state_q != IDLE) begin
      periodCnt_d = (periodCnt_q == CntMax) ? '0 : periodCnt_q + 16'd1;
    end else begin
      periodCnt_d = '0;
    end

    if (state_q != IDLE) begin
      divCnt_d = divTick ? '0 : divCnt_q + 8'd1;
    end

    if (fs_q) begin
      if (fsCnt_q == FsMax) begin
        fs_d = 1'b0;
      end else begin
        fsCnt_d = fsCnt_q + 16'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (startEvt) begin
          state_d = SETUP;
          csN_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      SETUP: begin
        if (divTick) begin
          state_d  = SHIFT;
          sclk_d   = 1'b1;
          bitCnt_d = '0;
        end
      end
      SHIFT: begin
        // MISO is captured on the same edge that drops SCLK; the final low phase
        // completes before HOLD starts.
        if (divTick) begin
          if (sclk_q) begin
            sclk_d   = 1'b0;
            shift_d  = {shift_q[14:0], adc_miso};
            bitCnt_d = bitCnt_q + 5'd1;
          end else if (bitCnt_q == 5'd16) begin
            state_d = HOLD;
          end else begin
            sclk_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (divTick) begin
          state_d = IDLE;
          csN_d   = 1'b1;
          busy_d  = 1'b0;
          dout_d  = {~shift_q[11], shift_q[10:0]};
          fs_d    = 1'b1;
          fsCnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign adc_cs_n = csN_q;
  assign adc_sclk = sclk_q;
  assign dout     = dout_q;
  assign f_s      = fs_q;
  assign busy     = busy_q;

endmodule
